// File: rtl/contador_uns_acumulador.sv
// contador_uns_acumulador: streaming ones-counter with per-frame totals.
// Each accepted word reports its popcount one cycle later. The block also
// accumulates saturating per-frame sums of 1 bits and words, and offers
// them on a result handshake that may apply backpressure.
module contador_uns_acumulador #(
    parameter int LARGURA     = 8,
    parameter int LARGURA_ACC = 16,
    localparam int CONT_W     = $clog2(LARGURA + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LARGURA-1:0]     entrada,
    input  logic                   entrada_valida,
    input  logic                   entrada_ultima,
    output logic                   entrada_pronta,
    output logic [CONT_W-1:0]      saida_quant_um,
    output logic                   saida_palavra_valida,
    output logic [LARGURA_ACC-1:0] total_quant_um,
    output logic [LARGURA_ACC-1:0] total_palavras,
    output logic                   saturado,
    output logic                   total_valido,
    input  logic                   total_pronto
);

    localparam logic [1:0] OCIOSO     = 2'd0;
    localparam logic [1:0] ACUMULANDO = 2'd1;
    localparam logic [1:0] ENTREGANDO = 2'd2;

    // Sum width wide enough for either operand plus a carry, so a popcount
    // wider than the accumulator still clamps correctly.
    localparam int SUM_W = ((CONT_W > LARGURA_ACC) ? CONT_W : LARGURA_ACC) + 1;
    localparam logic [LARGURA_ACC-1:0] ACC_MAX = {LARGURA_ACC{1'b1}};

    logic [1:0]             estado;
    logic [LARGURA_ACC-1:0] acc_um;
    logic [LARGURA_ACC-1:0] acc_pal;
    logic                   sat;

    logic                   aceita;
    logic [CONT_W-1:0]      quant_p0;
    logic [LARGURA_ACC:0]   soma_um_p0;
    logic [LARGURA_ACC:0]   soma_pal_p0;
    logic                   sat_p0;

    function automatic logic [CONT_W-1:0] popcount(input logic [LARGURA-1:0] palavra);
        logic [CONT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < LARGURA; i++) begin
            cnt = cnt + CONT_W'(palavra[i]);
        end
        return cnt;
    endfunction

    // Returns {clamped, value}: unsigned add that clamps at the accumulator maximum.
    function automatic logic [LARGURA_ACC:0] sat_add(input logic [LARGURA_ACC-1:0] acc,
                                                     input logic [CONT_W-1:0]      inc);
        logic [SUM_W-1:0] soma;
        soma = SUM_W'(acc) + SUM_W'(inc);
        if (soma > SUM_W'(ACC_MAX)) begin
            return {1'b1, ACC_MAX};
        end
        return {1'b0, soma[LARGURA_ACC-1:0]};
    endfunction

    // Ready is a pure state decode; no path from total_pronto.
    assign entrada_pronta = !reset && (estado != ENTREGANDO);
    assign aceita         = entrada_valida && entrada_pronta;

    // Popcount and the candidate accumulator updates for the offered word.
    always_comb begin
        quant_p0    = popcount(entrada);
        soma_um_p0  = sat_add(acc_um, quant_p0);
        soma_pal_p0 = sat_add(acc_pal, CONT_W'(1));
        sat_p0      = sat || soma_um_p0[LARGURA_ACC] || soma_pal_p0[LARGURA_ACC];
    end

    // Frame state, accumulators, per-word result and frame result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado               <= OCIOSO;
            acc_um               <= '0;
            acc_pal              <= '0;
            sat                  <= 1'b0;
            saida_quant_um       <= '0;
            saida_palavra_valida <= 1'b0;
            total_quant_um       <= '0;
            total_palavras       <= '0;
            saturado             <= 1'b0;
            total_valido         <= 1'b0;
        end else begin
            saida_palavra_valida <= 1'b0;
            if (aceita) begin
                saida_quant_um       <= quant_p0;
                saida_palavra_valida <= 1'b1;
                if (entrada_ultima) begin
                    total_quant_um <= soma_um_p0[LARGURA_ACC-1:0];
                    total_palavras <= soma_pal_p0[LARGURA_ACC-1:0];
                    saturado       <= sat_p0;
                    total_valido   <= 1'b1;
                    acc_um         <= '0;
                    acc_pal        <= '0;
                    sat            <= 1'b0;
                    estado         <= ENTREGANDO;
                end else begin
                    acc_um  <= soma_um_p0[LARGURA_ACC-1:0];
                    acc_pal <= soma_pal_p0[LARGURA_ACC-1:0];
                    sat     <= sat_p0;
                    estado  <= ACUMULANDO;
                end
            end else if (total_valido && total_pronto) begin
                // Totals and saturado keep their values after delivery.
                total_valido <= 1'b0;
                estado       <= OCIOSO;
            end
        end
    end

endmodule

// File: tb/tb_contador_uns_acumulador.sv
// Directed bench for contador_uns_acumulador: a default instance plus a
// 4-bit-accumulator instance sharing the same stimulus.
module tb_contador_uns_acumulador;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] entrada;
    logic       entrada_valida;
    logic       entrada_ultima;
    logic       total_pronto;

    logic        entrada_pronta;
    logic [3:0]  saida_quant_um;
    logic        saida_palavra_valida;
    logic [15:0] total_quant_um;
    logic [15:0] total_palavras;
    logic        saturado;
    logic        total_valido;

    logic        entrada_pronta_s;
    logic [3:0]  saida_quant_um_s;
    logic        saida_palavra_valida_s;
    logic [3:0]  total_quant_um_s;
    logic [3:0]  total_palavras_s;
    logic        saturado_s;
    logic        total_valido_s;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    contador_uns_acumulador dut (
        .clk(clk), .reset(reset), .entrada(entrada),
        .entrada_valida(entrada_valida), .entrada_ultima(entrada_ultima),
        .entrada_pronta(entrada_pronta), .saida_quant_um(saida_quant_um),
        .saida_palavra_valida(saida_palavra_valida),
        .total_quant_um(total_quant_um), .total_palavras(total_palavras),
        .saturado(saturado), .total_valido(total_valido),
        .total_pronto(total_pronto)
    );

    contador_uns_acumulador #(.LARGURA(8), .LARGURA_ACC(4)) dut_s (
        .clk(clk), .reset(reset), .entrada(entrada),
        .entrada_valida(entrada_valida), .entrada_ultima(entrada_ultima),
        .entrada_pronta(entrada_pronta_s), .saida_quant_um(saida_quant_um_s),
        .saida_palavra_valida(saida_palavra_valida_s),
        .total_quant_um(total_quant_um_s), .total_palavras(total_palavras_s),
        .saturado(saturado_s), .total_valido(total_valido_s),
        .total_pronto(total_pronto)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic u);
        entrada_valida = v;
        entrada        = d;
        entrada_ultima = u;
    endtask

    task automatic test_reset();
        reset = 1'b1; total_pronto = 1'b1;
        drive(1'b1, 8'hFF, 1'b1);
        for (int c = 0; c < 2; c++) begin
            step();
            n_chk++; if (entrada_pronta !== 1'b0) begin n_fail++; $display("FAIL rst_pronta got %0b exp 0", entrada_pronta); end
            n_chk++; if ({saida_quant_um, saida_palavra_valida, total_quant_um, total_palavras, saturado, total_valido} !== '0) begin n_fail++; $display("FAIL rst_outputs got q=%0d p=%0b t=%0d w=%0d s=%0b v=%0b exp all 0", saida_quant_um, saida_palavra_valida, total_quant_um, total_palavras, saturado, total_valido); end
        end
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        #1;
        n_chk++; if (entrada_pronta !== 1'b1) begin n_fail++; $display("FAIL rst_release_pronta got %0b exp 1", entrada_pronta); end
        step();
        n_chk++; if (saida_palavra_valida !== 1'b0 || total_valido !== 1'b0) begin n_fail++; $display("FAIL rst_no_accept got p=%0b v=%0b exp 0 0", saida_palavra_valida, total_valido); end
    endtask

    task automatic test_single_word();
        total_pronto = 1'b1;
        drive(1'b1, 8'b1011_0010, 1'b1);
        step();
        n_chk++; if (saida_quant_um !== 4'd4) begin n_fail++; $display("FAIL single_quant got %0d exp 4", saida_quant_um); end
        n_chk++; if (saida_palavra_valida !== 1'b1) begin n_fail++; $display("FAIL single_pulse got %0b exp 1", saida_palavra_valida); end
        n_chk++; if (total_quant_um !== 16'd4) begin n_fail++; $display("FAIL single_total got %0d exp 4", total_quant_um); end
        n_chk++; if (total_palavras !== 16'd1) begin n_fail++; $display("FAIL single_words got %0d exp 1", total_palavras); end
        n_chk++; if (saturado !== 1'b0 || total_valido !== 1'b1) begin n_fail++; $display("FAIL single_flags got s=%0b v=%0b exp 0 1", saturado, total_valido); end
        n_chk++; if (entrada_pronta !== 1'b0) begin n_fail++; $display("FAIL single_pronta got %0b exp 0", entrada_pronta); end
        drive(1'b0, 8'h00, 1'b0);
        step();
        n_chk++; if (total_valido !== 1'b0 || saida_palavra_valida !== 1'b0) begin n_fail++; $display("FAIL single_after got v=%0b p=%0b exp 0 0", total_valido, saida_palavra_valida); end
        n_chk++; if (saida_quant_um !== 4'd4 || total_quant_um !== 16'd4) begin n_fail++; $display("FAIL single_hold got q=%0d t=%0d exp 4 4", saida_quant_um, total_quant_um); end
        n_chk++; if (entrada_pronta !== 1'b1) begin n_fail++; $display("FAIL single_pronta_back got %0b exp 1", entrada_pronta); end
    endtask

    task automatic test_multi_gaps();
        logic [7:0] w   [6] = '{8'hFF, 8'hAA, 8'h00, 8'h0F, 8'h55, 8'h81};
        logic       v   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       u   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] q   [6] = '{4'd8, 4'd8, 4'd0, 4'd4, 4'd4, 4'd2};
        total_pronto = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(v[i], w[i], u[i]);
            step();
            n_chk++; if (saida_quant_um !== q[i] || saida_palavra_valida !== v[i]) begin n_fail++; $display("FAIL multi_word%0d got q=%0d p=%0b exp %0d %0b", i, saida_quant_um, saida_palavra_valida, q[i], v[i]); end
            if (i < 5) begin
                n_chk++; if (total_valido !== 1'b0) begin n_fail++; $display("FAIL multi_early_total%0d got %0b exp 0", i, total_valido); end
            end
        end
        n_chk++; if (total_quant_um !== 16'd14 || total_palavras !== 16'd4 || total_valido !== 1'b1 || saturado !== 1'b0) begin n_fail++; $display("FAIL multi_total got t=%0d w=%0d v=%0b s=%0b exp 14 4 1 0", total_quant_um, total_palavras, total_valido, saturado); end
        drive(1'b0, 8'h00, 1'b0);
        step();
    endtask

    task automatic test_backpressure();
        total_pronto = 1'b0;
        drive(1'b1, 8'h03, 1'b1);
        step();
        n_chk++; if (total_valido !== 1'b1 || total_quant_um !== 16'd2 || total_palavras !== 16'd1) begin n_fail++; $display("FAIL bp_first got v=%0b t=%0d w=%0d exp 1 2 1", total_valido, total_quant_um, total_palavras); end
        drive(1'b1, 8'hFF, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step();
            n_chk++; if (total_valido !== 1'b1 || total_quant_um !== 16'd2 || total_palavras !== 16'd1) begin n_fail++; $display("FAIL bp_hold%0d got v=%0b t=%0d w=%0d exp 1 2 1", c, total_valido, total_quant_um, total_palavras); end
            n_chk++; if (entrada_pronta !== 1'b0 || saida_palavra_valida !== 1'b0 || saida_quant_um !== 4'd2) begin n_fail++; $display("FAIL bp_block%0d got r=%0b p=%0b q=%0d exp 0 0 2", c, entrada_pronta, saida_palavra_valida, saida_quant_um); end
        end
        total_pronto = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        step();
        n_chk++; if (total_valido !== 1'b0 || entrada_pronta !== 1'b1) begin n_fail++; $display("FAIL bp_release got v=%0b r=%0b exp 0 1", total_valido, entrada_pronta); end
        drive(1'b1, 8'h01, 1'b1);
        step();
        n_chk++; if (total_quant_um !== 16'd1 || total_palavras !== 16'd1 || total_valido !== 1'b1) begin n_fail++; $display("FAIL bp_next got t=%0d w=%0d v=%0b exp 1 1 1", total_quant_um, total_palavras, total_valido); end
        drive(1'b0, 8'h00, 1'b0);
        step();
    endtask

    task automatic test_saturation();
        total_pronto = 1'b1;
        drive(1'b1, 8'hFF, 1'b0);
        step();
        step();
        drive(1'b1, 8'hFF, 1'b1);
        step();
        n_chk++; if (total_quant_um_s !== 4'd15 || total_palavras_s !== 4'd3 || saturado_s !== 1'b1 || total_valido_s !== 1'b1) begin n_fail++; $display("FAIL sat_total got t=%0d w=%0d s=%0b v=%0b exp 15 3 1 1", total_quant_um_s, total_palavras_s, saturado_s, total_valido_s); end
        n_chk++; if (total_quant_um !== 16'd24 || total_palavras !== 16'd3 || saturado !== 1'b0) begin n_fail++; $display("FAIL sat_wide got t=%0d w=%0d s=%0b exp 24 3 0", total_quant_um, total_palavras, saturado); end
        drive(1'b0, 8'h00, 1'b0);
        step();
        drive(1'b1, 8'h01, 1'b1);
        step();
        n_chk++; if (saturado_s !== 1'b0 || total_quant_um_s !== 4'd1 || total_palavras_s !== 4'd1) begin n_fail++; $display("FAIL sat_clear got s=%0b t=%0d w=%0d exp 0 1 1", saturado_s, total_quant_um_s, total_palavras_s); end
        drive(1'b0, 8'h00, 1'b0);
        step();
    endtask

    task automatic test_reset_mid_frame();
        total_pronto = 1'b1;
        drive(1'b1, 8'hFF, 1'b0);
        step();
        drive(1'b1, 8'hF0, 1'b0);
        step();
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        step();
        reset = 1'b0;
        n_chk++; if (total_valido !== 1'b0 || saida_quant_um !== 4'd0 || total_quant_um !== 16'd0) begin n_fail++; $display("FAIL mid_rst got v=%0b q=%0d t=%0d exp 0 0 0", total_valido, saida_quant_um, total_quant_um); end
        step();
        n_chk++; if (total_valido !== 1'b0) begin n_fail++; $display("FAIL mid_no_total got %0b exp 0", total_valido); end
        drive(1'b1, 8'h11, 1'b1);
        step();
        n_chk++; if (total_quant_um !== 16'd2 || total_palavras !== 16'd1 || total_valido !== 1'b1) begin n_fail++; $display("FAIL mid_next got t=%0d w=%0d v=%0b exp 2 1 1", total_quant_um, total_palavras, total_valido); end
        drive(1'b0, 8'h00, 1'b0);
        step();
    endtask

    initial begin
        reset = 1'b1;
        total_pronto = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        #1;
        test_reset();
        test_single_word();
        test_multi_gaps();
        test_backpressure();
        test_saturation();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/contador_uns_acumulador.md
# contador_uns_acumulador

Parametrised streaming ones-counter. The block accepts a stream of LARGURA-bit words under a valid/ready handshake and reports the per-word count of 1 bits. It also accumulates a saturating per-frame total of 1 bits and accepted words, and delivers both on a second valid/ready handshake that can apply backpressure. It is the sequential, frame-aware generalisation of the team's combinational 8-bit ones counter and sits between a word source and any consumer of per-frame bit statistics.

## Interface
- LARGURA, 8: input word width, ≥1.
- LARGURA_ACC, 16: width of both frame accumulators, ≥2.
- CONT_W, derived = $clog2(LARGURA+1): per-word count width. Not overridable.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- entrada  in  LARGURA  data word.
- entrada_valida  in  1  source offers entrada.
- entrada_ultima  in  1  marks the offered word as the last of its frame.
- entrada_pronta  out  1  block can accept a word.
- saida_quant_um  out  CONT_W  count of 1 bits in the last accepted word.
- saida_palavra_valida  out  1  one-cycle pulse marking a new saida_quant_um.
- total_quant_um  out  LARGURA_ACC  frame sum of 1 bits, saturating.
- total_palavras  out  LARGURA_ACC  frame word count, saturating.
- saturado  out  1  either total saturated during the frame being reported.
- total_valido  out  1  frame result offered.
- total_pronto  in  1  consumer accepts the frame result.

## Operation
- Accept: an input word is accepted on a rising edge where entrada_valida && entrada_pronta. Input fields are ignored in every other cycle.
- States:
  - OCIOSO: no word accepted in the current frame.
  - ACUMULANDO: at least one word accepted, last word not yet seen.
  - ENTREGANDO: frame result is being offered.
- Transitions:
  - OCIOSO→ACUMULANDO on an accept with entrada_ultima=0.
  - OCIOSO or ACUMULANDO→ENTREGANDO on an accept with entrada_ultima=1. A single-word frame is legal.
  - ENTREGANDO→OCIOSO on the edge where total_valido && total_pronto.
- entrada_pronta = !reset && state != ENTREGANDO. It is decoded from state, with no combinational path from total_pronto. No word is accepted in the same cycle as the result handshake.
- On each accept:
  - saida_quant_um <= popcount(entrada).
  - saida_palavra_valida <= 1 for exactly one cycle. Otherwise 0; saida_quant_um holds its value.
  - acc_um <= min(acc_um + popcount, 2^LARGURA_ACC−1).
  - acc_pal <= min(acc_pal + 1, 2^LARGURA_ACC−1).
  - Saturation on either accumulator sets the sticky internal sat flag.
- On the accept with entrada_ultima=1:
  - total_quant_um, total_palavras and saturado are loaded with the updated values, including the last word.
  - total_valido <= 1.
  - The internal accumulators and sat are cleared on the same edge.
- In ENTREGANDO, total_* and saturado hold stable until the handshake. On the handshake edge total_valido <= 0; total_* and saturado keep their values.
- Arithmetic: all sums are unsigned. Saturation is a clamp, never a wrap.

## Timing
- Reset values: state OCIOSO; saida_quant_um=0, saida_palavra_valida=0, total_quant_um=0, total_palavras=0, saturado=0, total_valido=0; accumulators and sat = 0. entrada_pronta=0 while reset=1 and 1 in the first cycle after release.
- Per-word latency: 1 cycle. A word accepted at edge N is visible on saida_quant_um and saida_palavra_valida after edge N.
- Frame latency: 1 cycle after the last-word accept edge.
- Throughput: one word per cycle while no result is pending. After a result handshake, the next frame can start one cycle later.
- Reset asserted mid-frame or during ENTREGANDO discards the partial frame and any pending result. No total is emitted for it.
- Input gaps (entrada_valida=0) in ACUMULANDO leave all state unchanged.

## Test plan
- Reset: hold reset 2 cycles with entrada_valida=1 → all outputs 0 and entrada_pronta=0 during reset; entrada_pronta=1 on the first cycle after release; no accept while reset=1.
- Single-word frame, LARGURA=8: entrada=8'b1011_0010 with ultima=1, total_pronto=1 → next cycle saida_quant_um=4 and pulse, total_quant_um=4, total_palavras=1, saturado=0, total_valido=1 for one cycle.
- Multi-word frame with gaps: 0xFF, idle, 0x00, 0x0F, idle, 0x81 (last) → per-word 8,0,4,2 with four single-cycle pulses; total_quant_um=14, total_palavras=4.
- Backpressure: total_pronto=0 for 5 cycles after frame {0x03 last} → total_valido, total_quant_um=2 and total_palavras=1 held; entrada_pronta=0; offered words not accepted. Raise total_pronto → total_valido=0 next cycle; the following frame {0x01 last} gives total_quant_um=1, proving the accumulators cleared.
- Saturation with LARGURA_ACC=4: frame 0xFF, 0xFF, 0xFF (last) → total_quant_um=15, total_palavras=3, saturado=1. The next frame {0x01 last} gives saturado=0.
- Reset mid-frame: accept 0xFF and 0xF0, pulse reset for 1 cycle, then frame {0x11 last} → no total for the aborted frame; total_quant_um=2, total_palavras=1.
